// File: rtl/car_cmd_ctrl.sv
// Decodes UART command bytes into motor direction and servo angle.
// Two-cycle latency from the first synchronised rx_finish sample; a watchdog halts the motor when commands stop arriving.
module car_cmd_ctrl #(
  parameter int ANGLE_W       = 8,
  parameter int MIN_ANGLE     = 195,
  parameter int MAX_ANGLE     = 255,
  parameter int DEFAULT_ANGLE = 225,
  parameter int STEP          = 1,
  parameter int WD_CYCLES     = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               rx_finish,
  input  logic               rx_error,
  input  logic [7:0]         rx_data,
  output logic [ANGLE_W-1:0] angle,
  output logic [1:0]         direction,
  output logic               cmd_strobe,
  output logic [7:0]         bad_cmd_cnt,
  output logic               wd_timeout
);

  localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  localparam logic [ANGLE_W:0]   MAX_X         = (ANGLE_W+1)'(MAX_ANGLE);
  localparam logic [ANGLE_W:0]   STEP_X        = (ANGLE_W+1)'(STEP);
  localparam logic [ANGLE_W:0]   MIN_PLUS_STEP = (ANGLE_W+1)'(MIN_ANGLE + STEP);
  localparam logic [ANGLE_W-1:0] MIN_A         = ANGLE_W'(MIN_ANGLE);
  localparam logic [ANGLE_W-1:0] MAX_A         = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] DEF_A         = ANGLE_W'(DEFAULT_ANGLE);
  localparam logic [ANGLE_W-1:0] STEP_A        = ANGLE_W'(STEP);

  localparam logic [1:0] DIR_FWD  = 2'b11;
  localparam logic [1:0] DIR_BWD  = 2'b00;
  localparam logic [1:0] DIR_HALT = 2'b01;

  logic [2:0]         sync_q;
  logic [2:0]         sync_vld_q;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [1:0]         dir_q, dir_d;
  logic               strobe_q;
  logic [7:0]         bad_q, bad_d;
  logic               wd_to_q, wd_to_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;

  logic               byte_evt, accept, reject;
  logic [ANGLE_W:0]   angle_up;
  logic [ANGLE_W-1:0] angle_dn;

  // sync_vld_q marks which synchroniser stages hold a real post-reset sample, so
  // an rx_finish that is already high across reset never looks like a new edge.
  assign byte_evt = sync_q[1] & ~sync_q[2] & sync_vld_q[2];
  assign accept   = byte_evt & ~rx_error & (rx_data[1:0] == 2'b00);
  assign reject   = byte_evt & ~accept;
  assign angle_up = {1'b0, angle_q} + STEP_X;
  assign angle_dn = angle_q - STEP_A;

  always_comb begin
    angle_d  = angle_q;
    dir_d    = dir_q;
    bad_d    = bad_q;
    wd_to_d  = wd_to_q;
    wd_cnt_d = wd_cnt_q;

    if (reject && bad_q != 8'hFF) bad_d = bad_q + 8'd1;

    if (accept) begin
      case (rx_data[7:5])
        3'b011:  dir_d = DIR_FWD;
        3'b110:  dir_d = DIR_BWD;
        default: dir_d = DIR_HALT;
      endcase
      case (rx_data[4:2])
        3'b011:  angle_d = (angle_up > MAX_X) ? MAX_A : angle_up[ANGLE_W-1:0];
        3'b110:  angle_d = ({1'b0, angle_q} < MIN_PLUS_STEP) ? MIN_A : angle_dn;
        3'b101:  angle_d = DEF_A;
        default: angle_d = angle_q;
      endcase
      wd_to_d  = 1'b0;
      wd_cnt_d = '0;
    end else if (WD_CYCLES > 0 && dir_q != DIR_HALT) begin
      if (wd_cnt_q == WD_LAST) begin
        dir_d   = DIR_HALT;
        wd_to_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_q     <= 3'b000;
      sync_vld_q <= 3'b000;
      angle_q    <= DEF_A;
      dir_q      <= DIR_HALT;
      strobe_q   <= 1'b0;
      bad_q      <= 8'd0;
      wd_to_q    <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      sync_q     <= {sync_q[1:0], rx_finish};
      sync_vld_q <= {sync_vld_q[1:0], 1'b1};
      angle_q    <= angle_d;
      dir_q      <= dir_d;
      strobe_q   <= accept;
      bad_q      <= bad_d;
      wd_to_q    <= wd_to_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign angle       = angle_q;
  assign direction   = dir_q;
  assign cmd_strobe  = strobe_q;
  assign bad_cmd_cnt = bad_q;
  assign wd_timeout  = wd_to_q;

endmodule

// File: tb/tb_car_cmd_ctrl.sv
// Directed bench: dut_a (STEP=1, WD_CYCLES=100) and dut_b (STEP=4, watchdog off) share one UART stimulus.
module tb_car_cmd_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rx_finish;
  logic       rx_error;
  logic [7:0] rx_data;

  logic [7:0] angle_a, angle_b;
  logic [1:0] dir_a, dir_b;
  logic       stb_a, stb_b;
  logic [7:0] bad_a, bad_b;
  logic       wd_a, wd_b;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt_a = 0;
  int stb_cnt_b = 0;
  int stb_ref_a, stb_ref_b;

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (stb_a) stb_cnt_a++;
    if (stb_b) stb_cnt_b++;
  end

  car_cmd_ctrl #(
    .ANGLE_W(8), .MIN_ANGLE(195), .MAX_ANGLE(255), .DEFAULT_ANGLE(225),
    .STEP(1), .WD_CYCLES(100)
  ) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_finish(rx_finish), .rx_error(rx_error),
    .rx_data(rx_data), .angle(angle_a), .direction(dir_a), .cmd_strobe(stb_a),
    .bad_cmd_cnt(bad_a), .wd_timeout(wd_a)
  );

  car_cmd_ctrl #(
    .ANGLE_W(8), .MIN_ANGLE(195), .MAX_ANGLE(255), .DEFAULT_ANGLE(225),
    .STEP(4), .WD_CYCLES(0)
  ) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_finish(rx_finish), .rx_error(rx_error),
    .rx_data(rx_data), .angle(angle_b), .direction(dir_b), .cmd_strobe(stb_b),
    .bad_cmd_cnt(bad_b), .wd_timeout(wd_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Raises rx_finish before edge k and returns 1ns after edge k+2, when the byte has been applied.
  task automatic apply_byte(input logic [7:0] d, input logic err);
    @(negedge sys_clk);
    rx_data   = d;
    rx_error  = err;
    rx_finish = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    rx_finish = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic err);
    apply_byte(d, err);
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_finish = 1'b0;
    rx_error  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;

    check("rst_angle_a", angle_a, 225);
    check("rst_dir_a",   dir_a,   2'b01);
    check("rst_bad_a",   bad_a,   0);
    check("rst_wd_a",    wd_a,    0);
    check("rst_stb_a",   stb_cnt_a, 0);
    check("rst_angle_b", angle_b, 225);
    check("rst_dir_b",   dir_b,   2'b01);

    // latency of 0x6C: first high sample at edge k, update at k+2
    @(negedge sys_clk);
    rx_data = 8'h6C; rx_error = 1'b0; rx_finish = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("lat_k_stb", stb_a, 0);
    @(negedge sys_clk);
    check("lat_k1_stb",   stb_a,   0);
    check("lat_k1_angle", angle_a, 225);
    @(negedge sys_clk);
    check("lat_k2_stb",   stb_a,   1);
    check("lat_k2_angle", angle_a, 226);
    check("lat_k2_dir",   dir_a,   2'b11);
    check("lat_k2_angle_b", angle_b, 229);
    rx_finish = 1'b0;
    @(negedge sys_clk);
    check("lat_k3_stb", stb_a, 0);
    repeat (3) @(posedge sys_clk);
    #1;

    send_byte(8'hD8, 1'b0);
    check("bwd_dir_a",   dir_a,   2'b00);
    check("bwd_angle_a", angle_a, 225);
    check("bwd_angle_b", angle_b, 225);

    for (int i = 0; i < 20; i++) send_byte(8'h0C, 1'b0);
    check("left_angle_a", angle_a, 245);
    check("left_angle_b", angle_b, 255);
    check("left_dir_a",   dir_a,   2'b01);

    for (int i = 0; i < 20; i++) send_byte(8'h18, 1'b0);
    check("right_angle_a", angle_a, 225);
    check("right_angle_b", angle_b, 195);

    send_byte(8'h14, 1'b0);
    check("straight_angle_a", angle_a, 225);
    check("straight_angle_b", angle_b, 225);

    send_byte(8'h6D, 1'b0);
    send_byte(8'h6C, 1'b1);
    check("rej_bad_a",   bad_a,   2);
    check("rej_bad_b",   bad_b,   2);
    check("rej_dir_a",   dir_a,   2'b01);
    check("rej_angle_b", angle_b, 225);
    check("rej_stb_a",   stb_cnt_a, 43);
    check("rej_stb_b",   stb_cnt_b, 43);

    for (int i = 0; i < 298; i++) send_byte(8'h6D, 1'b0);
    check("sat_bad_a", bad_a, 255);
    check("sat_bad_b", bad_b, 255);

    // watchdog expiry exactly 100 cycles after the applying edge
    apply_byte(8'h60, 1'b0);
    check("wd_fwd_stb", stb_a, 1);
    check("wd_fwd_dir", dir_a, 2'b11);
    repeat (99) @(posedge sys_clk);
    #1;
    check("wd_99_dir", dir_a, 2'b11);
    check("wd_99_to",  wd_a,  0);
    @(posedge sys_clk);
    #1;
    check("wd_100_dir",   dir_a,   2'b01);
    check("wd_100_to",    wd_a,    1);
    check("wd_100_angle", angle_a, 225);
    check("wd_off_dir_b", dir_b,   2'b11);
    check("wd_off_to_b",  wd_b,    0);
    repeat (20) @(posedge sys_clk);
    #1;
    check("wd_hold_dir", dir_a, 2'b01);
    check("wd_hold_to",  wd_a,  1);

    apply_byte(8'h60, 1'b0);
    check("wd_clr_dir", dir_a, 2'b11);
    check("wd_clr_to",  wd_a,  0);
    repeat (97) @(posedge sys_clk);
    apply_byte(8'h60, 1'b0);
    check("wd_race_dir", dir_a, 2'b11);
    check("wd_race_to",  wd_a,  0);
    @(posedge sys_clk);
    #1;
    check("wd_race_next_dir", dir_a, 2'b11);
    repeat (98) @(posedge sys_clk);
    #1;
    check("wd_race_99_dir", dir_a, 2'b11);
    @(posedge sys_clk);
    #1;
    check("wd_race_100_dir", dir_a, 2'b01);
    check("wd_race_100_to",  wd_a,  1);
    check("stb_total_a", stb_cnt_a, 46);

    // reset while rx_finish is high, released with it still high
    stb_ref_a = stb_cnt_a;
    stb_ref_b = stb_cnt_b;
    @(negedge sys_clk);
    rx_data = 8'h6C; rx_error = 1'b0; rx_finish = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (8) @(posedge sys_clk);
    #1;
    check("rstmid_stb_a", stb_cnt_a, stb_ref_a);
    check("rstmid_stb_b", stb_cnt_b, stb_ref_b);
    check("rstmid_angle", angle_a, 225);
    check("rstmid_dir_a", dir_a,   2'b01);
    check("rstmid_dir_b", dir_b,   2'b01);
    check("rstmid_bad_a", bad_a,   0);
    check("rstmid_wd_a",  wd_a,    0);
    rx_finish = 1'b0;
    repeat (5) @(posedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
